// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Holds the 640x480@60 defaults, an 800x600@60 set and axis helpers.
package vga_timing_pkg;

    localparam int VGA640_H_DISPLAY = 640;
    localparam int VGA640_H_FRONT   = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BACK    = 48;
    localparam int VGA640_V_DISPLAY = 480;
    localparam int VGA640_V_FRONT   = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BACK    = 33;
    localparam bit VGA640_H_POL     = 1'b0;
    localparam bit VGA640_V_POL     = 1'b0;

    localparam int SVGA800_H_DISPLAY = 800;
    localparam int SVGA800_H_FRONT   = 40;
    localparam int SVGA800_H_SYNC    = 128;
    localparam int SVGA800_H_BACK    = 88;
    localparam int SVGA800_V_DISPLAY = 600;
    localparam int SVGA800_V_FRONT   = 1;
    localparam int SVGA800_V_SYNC    = 4;
    localparam int SVGA800_V_BACK    = 23;
    localparam bit SVGA800_H_POL     = 1'b1;
    localparam bit SVGA800_V_POL     = 1'b1;

    function automatic int axis_total(int d, int f, int s, int b);
        return d + f + s + b;
    endfunction

    // Sync covers [sync_start, sync_end) on the raw axis count.
    function automatic int sync_start(int d, int f);
        return d + f;
    endfunction

    function automatic int sync_end(int d, int f, int s);
        return d + f + s;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus active and sync decode.
// Ports: clk, rst, step in; count, wrap, active, sync_level out.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_W   = 10,
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter bit POL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync_level
);

    localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);
    localparam int S0    = sync_start(DISPLAY, FRONT);
    localparam int S1    = sync_end(DISPLAY, FRONT, SYNC);

    // Porches may be empty; display and sync may not, and the
    // axis must fit the counter width.
    if (DISPLAY < 1 || SYNC < 1 || FRONT < 0 || BACK < 0 ||
        CNT_W < 1 || CNT_W > 30 || TOTAL > (1 << CNT_W)) begin : g_bad
        $error("vga_axis_counter: illegal axis parameters");
    end

    logic [31:0] cnt32;
    logic        last;

    assign cnt32 = 32'(count);
    assign last  = (cnt32 == 32'(TOTAL - 1));
    assign wrap  = step && last;

    assign active     = (cnt32 < 32'(DISPLAY));
    assign sync_level = (cnt32 >= 32'(S0) && cnt32 < 32'(S1)) ? POL : ~POL;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with registered, aligned outputs.
// Ports: clk, rst, pix_ce, irq_line in; pixel_x/y, video_on, h/v_sync,
// line_start, frame_start, frame_count, line_irq out.
// Optional macro VGA_TIMING_LINE_IRQ_EN enables the line interrupt.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = VGA640_H_DISPLAY,
    parameter int H_FRONT    = VGA640_H_FRONT,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BACK     = VGA640_H_BACK,
    parameter int V_DISPLAY  = VGA640_V_DISPLAY,
    parameter int V_FRONT    = VGA640_V_FRONT,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BACK     = VGA640_V_BACK,
    parameter bit H_SYNC_POL = VGA640_H_POL,
    parameter bit V_SYNC_POL = VGA640_V_POL,
    parameter int CNT_W      = 10,
    parameter int FC_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    input  logic [CNT_W-1:0] irq_line,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             h_sync,
    output logic             v_sync,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count,
    output logic             line_irq
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    logic             h_act, v_act;
    logic             h_lvl, v_lvl;
    logic             h_zero, v_zero;

    vga_axis_counter #(
        .CNT_W(CNT_W), .DISPLAY(H_DISPLAY), .FRONT(H_FRONT),
        .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_SYNC_POL)
    ) u_h (
        .clk(clk), .rst(rst), .step(pix_ce),
        .count(h_cnt), .wrap(h_wrap),
        .active(h_act), .sync_level(h_lvl)
    );

    // h_wrap already includes pix_ce.
    vga_axis_counter #(
        .CNT_W(CNT_W), .DISPLAY(V_DISPLAY), .FRONT(V_FRONT),
        .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_SYNC_POL)
    ) u_v (
        .clk(clk), .rst(rst), .step(h_wrap),
        .count(v_cnt), .wrap(v_wrap),
        .active(v_act), .sync_level(v_lvl)
    );

    assign h_zero = (h_cnt == '0);
    assign v_zero = (v_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            h_sync      <= ~H_SYNC_POL;
            v_sync      <= ~V_SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else if (pix_ce) begin
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            video_on    <= h_act && v_act;
            h_sync      <= h_lvl;
            v_sync      <= v_lvl;
            line_start  <= h_zero;
            frame_start <= h_zero && v_zero;
            if (v_wrap) begin
                frame_count <= frame_count + 1'b1;
            end
        end else begin
            // Strobes last one clk whatever the enable duty.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_LINE_IRQ_EN
    // v_cnt never reaches V_TOTAL, so out-of-range lines never fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_irq <= 1'b0;
        end else if (pix_ce) begin
            line_irq <= h_zero && (v_cnt == irq_line);
        end else begin
            line_irq <= 1'b0;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^irq_line;
    assign line_irq   = 1'b0;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator; successor to the fixed-mode 640x480 sync block. Produces h/v sync, video_on, pixel coordinates, line/frame strobes and a frame counter. All outputs come from registers and are aligned on the same cycle. A pixel clock-enable lets the block run off a faster system clock. Sits between the clock domain and the pixel/colour pipeline.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of h_sync (0 = active-low)
V_SYNC_POL, 0, active level of v_sync
CNT_W, 10, counter/coordinate width; 2^CNT_W must be at least H_TOTAL and V_TOTAL
FC_W, 8, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_ce  in  1  pixel clock enable; counters and outputs advance only when it is 1
pixel_x  out  CNT_W  horizontal count of the presented pixel
pixel_y  out  CNT_W  vertical count of the presented pixel
video_on  out  1  presented pixel is in the active area
h_sync  out  1  horizontal sync, polarity set by H_SYNC_POL
v_sync  out  1  vertical sync, polarity set by V_SYNC_POL
line_start  out  1  one-clk strobe when the presented pixel has x = 0
frame_start  out  1  one-clk strobe when the presented pixel is (0,0)
frame_count  out  FC_W  completed-frame counter

Behaviour:
- Derived constants: H_TOTAL = sum of the four H terms; V_TOTAL likewise. Internal counters are h_cnt and v_cnt, each CNT_W wide.
- Reset (rst = 1 at a clk edge, pix_ce ignored):
  - h_cnt = v_cnt = 0; pixel_x = pixel_y = 0.
  - video_on = 0; h_sync = ~H_SYNC_POL; v_sync = ~V_SYNC_POL.
  - line_start = frame_start = 0; frame_count = 0.
  - Reset mid-frame aborts the frame immediately, with no partial-sync completion.
- Counting, on a clk edge with pix_ce = 1:
  - h_cnt increments; when h_cnt = H_TOTAL-1 it wraps to 0.
  - On the h wrap, v_cnt increments; when v_cnt = V_TOTAL-1 it wraps to 0.
  - On the wrap of both counters, frame_count increments, modulo 2^FC_W.
- Output registers load on the same edge from the pre-increment counter values (h,v). Latency is exactly one enabled cycle, identical for every output.
  - pixel_x = h, pixel_y = v; these are raw counts and are valid in blanking too.
  - video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
  - h_sync = H_SYNC_POL when H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC, else the inverse.
  - v_sync uses the same rule on v with the V terms.
  - line_start = (h == 0); frame_start = (h == 0 && v == 0).
- With pix_ce = 0: counters and level outputs hold. line_start and frame_start clear to 0 on that edge, so each strobe lasts exactly one clk regardless of the pix_ce duty.
- First enabled edge after reset: outputs present (0,0); video_on = 1, line_start = frame_start = 1.
- Counters never exceed TOTAL-1. Illegal parameter sets (a total overflowing CNT_W, or any zero-width field other than porches) are rejected by an elaboration-time check.

Optional Feature:
VGA_TIMING_LINE_IRQ_EN
- Defined: adds input irq_line [CNT_W-1:0] and output line_irq.
  - line_irq is a one-clk strobe, aligned with line_start, when the presented pixel has h = 0 and v == irq_line.
  - irq_line is sampled on that same edge. A value of V_TOTAL or more never fires.
  - line_irq resets to 0.
- Undefined: both ports exist; line_irq is tied to 0 and irq_line is ignored. Integration is the same either way.

Decomposition:
- Package vga_timing_pkg:
  - Default 640x480@60 constants.
  - An 800x600 constant set.
  - A localparam function computing totals and sync start/end.
- Sub-module vga_axis_counter, instantiated twice (H and V):
  - Inputs: clk, rst, step, plus DISPLAY/FRONT/SYNC/BACK/POL parameters.
  - Outputs: count, wrap, active, sync_level.
  - The V instance steps on the H wrap qualified by pix_ce.

Test Plan:
- Defaults, pix_ce = 1 → line period 800 clk; h_sync low for 96 clk, starting when pixel_x = 656; v_sync low for 1600 clk; frame period 420000 clk; 307200 video_on clk per frame.
- Small parameters (H 4/1/2/1, V 3/1/1/1, CNT_W = 4) → pixel_x sequence 0..7 wraps; pixel_y 0..5 wraps; frame_count increments every 48 clk; wrap checked at FC_W = 2 (3 → 0).
- pix_ce high 1 clk in 4 → line period 3200 clk; line_start and frame_start stay exactly 1 clk wide; all outputs hold between enables.
- Assert rst at pixel (300,200) mid-frame → next clk: syncs inactive, pixel_x = pixel_y = 0, video_on = 0, frame_count = 0; first enabled edge afterwards gives frame_start = 1.
- H_SYNC_POL = V_SYNC_POL = 1 → sync pulses are active-high at the same positions; reset value 0.
- With VGA_TIMING_LINE_IRQ_EN and irq_line = 479 → line_irq asserts 1 clk per frame, coincident with line_start at pixel_y = 479. With irq_line = 600 → never fires.
